// File: rtl/muldiv_pkg.sv
// Shared types and defaults for the sequential RISC-V M-extension multiply/divide unit.
package muldiv_pkg;
  localparam int DEFAULT_DWIDTH = 32;
  localparam int DEFAULT_ITER   = DEFAULT_DWIDTH;

  typedef enum logic [2:0] {
    OP_MUL    = 3'b000,
    OP_MULH   = 3'b001,
    OP_MULHSU = 3'b010,
    OP_MULHU  = 3'b011,
    OP_DIV    = 3'b100,
    OP_DIVU   = 3'b101,
    OP_REM    = 3'b110,
    OP_REMU   = 3'b111
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_DONE
  } state_e;
endpackage

// File: rtl/muldiv_step.sv
// One iteration of shift-add multiply or restoring divide on unsigned magnitudes.
module muldiv_step #(
  parameter int DWIDTH = 32
) (
  input  logic              is_div_i,
  input  logic [DWIDTH-1:0] acc_i,
  input  logic [DWIDTH-1:0] lo_i,
  input  logic [DWIDTH-1:0] opb_i,
  output logic [DWIDTH-1:0] acc_o,
  output logic [DWIDTH-1:0] lo_o
);
  logic [DWIDTH:0]   sum;
  logic [DWIDTH:0]   shifted;
  logic [DWIDTH-1:0] diff;
  logic              ge;

  always_comb begin
    sum     = {1'b0, acc_i} + (lo_i[0] ? {1'b0, opb_i} : '0);
    shifted = {acc_i, lo_i[DWIDTH-1]};
    ge      = shifted >= {1'b0, opb_i};
    // Only consumed when ge, so the difference is below the divisor and fits in DWIDTH.
    diff    = shifted[DWIDTH-1:0] - opb_i;
    if (is_div_i) begin
      acc_o = ge ? diff : shifted[DWIDTH-1:0];
      lo_o  = {lo_i[DWIDTH-2:0], ge};
    end else begin
      acc_o = sum[DWIDTH:1];
      lo_o  = {sum[0], lo_i[DWIDTH-1:1]};
    end
  end
endmodule

// File: rtl/muldiv_seq.sv
// Sequential M-extension multiply/divide unit with IDLE/CALC/DONE control.
// Define MULDIV_FAST_MUL_EN to route multiplies through a single-cycle combinational multiplier.
module muldiv_seq
  import muldiv_pkg::*;
#(
  parameter int DWIDTH = DEFAULT_DWIDTH,
  parameter int ITER   = DWIDTH
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start_i,
  input  logic [2:0]        funct3_i,
  input  logic [DWIDTH-1:0] rs1_i,
  input  logic [DWIDTH-1:0] rs2_i,
  input  logic              kill_i,
  output logic              busy_o,
  output logic              done_o,
  output logic [DWIDTH-1:0] res_o
);
  localparam int CNT_W = $clog2(ITER + 1);

  state_e              state_q;
  op_e                 op_q;
  logic                neg_q, busy_q, done_q;
  logic [CNT_W-1:0]    cnt_q;
  logic [DWIDTH-1:0]   acc_q, lo_q, opb_q, res_q;
  logic [DWIDTH-1:0]   acc_d, lo_d;

  op_e                 op_in;
  logic                s1, s2, neg_in, rem_in, div0, ovf, fast_ok;
  logic [DWIDTH-1:0]   mag1, mag2, skip_res;
  logic [2*DWIDTH-1:0] fast_prod;

  function automatic logic [DWIDTH-1:0] finish(op_e op, logic neg,
                                               logic [DWIDTH-1:0] hi, logic [DWIDTH-1:0] lo);
    logic [2*DWIDTH-1:0] prod;
    prod = neg ? -{hi, lo} : {hi, lo};
    case (op)
      OP_MUL:                       return prod[DWIDTH-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU: return prod[2*DWIDTH-1:DWIDTH];
      OP_DIV, OP_DIVU:              return neg ? -lo : lo;
      default:                      return neg ? -hi : hi;
    endcase
  endfunction

  always_comb begin
    op_in  = op_e'(funct3_i);
    rem_in = (op_in == OP_REM) || (op_in == OP_REMU);
    s1     = (op_in inside {OP_MULH, OP_MULHSU, OP_DIV, OP_REM}) && rs1_i[DWIDTH-1];
    s2     = (op_in inside {OP_MULH, OP_DIV, OP_REM}) && rs2_i[DWIDTH-1];
    mag1   = s1 ? -rs1_i : rs1_i;
    mag2   = s2 ? -rs2_i : rs2_i;
    // Remainder takes the dividend's sign; quotient and product take the XOR of both.
    neg_in = rem_in ? s1 : (s1 ^ s2);
    div0   = funct3_i[2] && (rs2_i == '0);
    ovf    = ((op_in == OP_DIV) || (op_in == OP_REM)) &&
             (rs1_i == {1'b1, {(DWIDTH-1){1'b0}}}) && (rs2_i == '1);
    if (div0) skip_res = rem_in ? rs1_i : '1;
    else      skip_res = rem_in ? '0 : rs1_i;
  end

`ifdef MULDIV_FAST_MUL_EN
  assign fast_ok   = !funct3_i[2];
  assign fast_prod = {{DWIDTH{1'b0}}, mag1} * {{DWIDTH{1'b0}}, mag2};
`else
  assign fast_ok   = 1'b0;
  assign fast_prod = '0;
`endif

  muldiv_step #(.DWIDTH(DWIDTH)) u_step (
    .is_div_i (op_q[2]),
    .acc_i    (acc_q),
    .lo_i     (lo_q),
    .opb_i    (opb_q),
    .acc_o    (acc_d),
    .lo_o     (lo_d)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      res_q   <= '0;
      cnt_q   <= '0;
    end else if (kill_i) begin
      state_q <= S_IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          done_q <= 1'b0;
          if (start_i) begin
            op_q   <= op_in;
            neg_q  <= neg_in;
            acc_q  <= '0;
            lo_q   <= mag1;
            opb_q  <= mag2;
            cnt_q  <= CNT_W'(ITER - 1);
            busy_q <= 1'b1;
            if (div0 || ovf) begin
              res_q   <= skip_res;
              done_q  <= 1'b1;
              state_q <= S_DONE;
            end else if (fast_ok) begin
              res_q   <= finish(op_in, neg_in, fast_prod[2*DWIDTH-1:DWIDTH], fast_prod[DWIDTH-1:0]);
              done_q  <= 1'b1;
              state_q <= S_DONE;
            end else begin
              state_q <= S_CALC;
            end
          end
        end
        S_CALC: begin
          acc_q <= acc_d;
          lo_q  <= lo_d;
          cnt_q <= cnt_q - CNT_W'(1);
          if (cnt_q == '0) begin
            res_q   <= finish(op_q, neg_q, acc_d, lo_d);
            done_q  <= 1'b1;
            state_q <= S_DONE;
          end
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy_o = busy_q;
  assign done_o = done_q;
  assign res_o  = res_q;
endmodule

// File: tb/tb_muldiv_seq.sv
// Scoreboard bench for muldiv_seq: directed corner cases plus randomized ops against an arithmetic model.
module tb_muldiv_seq;
  localparam int W = 32;
  localparam int ITER = 32;

  logic         clk = 1'b0;
  logic         reset;
  logic         start_i;
  logic [2:0]   funct3_i;
  logic [W-1:0] rs1_i, rs2_i;
  logic         kill_i;
  logic         busy_o, done_o;
  logic [W-1:0] res_o;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  logic [W-1:0] last_res = '0;

  typedef struct {
    logic [W-1:0] res;
    int           lat;
    int           acc;
  } exp_t;
  exp_t sb[$];

  muldiv_seq dut (
    .clk      (clk),
    .reset    (reset),
    .start_i  (start_i),
    .funct3_i (funct3_i),
    .rs1_i    (rs1_i),
    .rs2_i    (rs2_i),
    .kill_i   (kill_i),
    .busy_o   (busy_o),
    .done_o   (done_o),
    .res_o    (res_o)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic logic [W-1:0] ref_fn(input logic [2:0] f, input logic [W-1:0] a,
                                          input logic [W-1:0] b);
    longint sa, sb2, ua, ub;
    logic [63:0] p;
    logic ovf;
    sa  = $signed(a);
    sb2 = $signed(b);
    ua  = {32'b0, a};
    ub  = {32'b0, b};
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (f)
      3'd0: begin p = ua * ub;  return p[31:0];  end
      3'd1: begin p = sa * sb2; return p[63:32]; end
      3'd2: begin p = sa * ub;  return p[63:32]; end
      3'd3: begin p = ua * ub;  return p[63:32]; end
      3'd4: begin
        if (b == 0) return '1;
        if (ovf) return a;
        p = sa / sb2; return p[31:0];
      end
      3'd5: begin
        if (b == 0) return '1;
        p = ua / ub; return p[31:0];
      end
      3'd6: begin
        if (b == 0) return a;
        if (ovf) return '0;
        p = sa % sb2; return p[31:0];
      end
      default: begin
        if (b == 0) return a;
        p = ua % ub; return p[31:0];
      end
    endcase
  endfunction

  function automatic int ref_lat(input logic [2:0] f, input logic [W-1:0] a, input logic [W-1:0] b);
    if (f[2] && b == 0) return 1;
    if ((f == 3'd4 || f == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
`ifdef MULDIV_FAST_MUL_EN
    if (!f[2]) return 1;
`endif
    return ITER + 1;
  endfunction

  function automatic logic [W-1:0] pick();
    case ($urandom_range(0, 6))
      0:       return '0;
      1:       return 32'h8000_0000;
      2:       return '1;
      3:       return W'($urandom_range(0, 20));
      4:       return -W'($urandom_range(1, 20));
      default: return $urandom;
    endcase
  endfunction

  // Monitor: every done pulse pops one expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!reset && done_o) begin
        if (sb.size() == 0) begin
          check("unexpected_done", {31'b0, done_o}, '0);
        end else begin
          e = sb.pop_front();
          check("result", res_o, e.res);
          check("latency", W'(cyc - e.acc + 1), W'(e.lat));
        end
      end
    end
  end

  task automatic wait_idle();
    for (int i = 0; i < 100 && busy_o; i++) @(negedge clk);
    if (busy_o) begin
      tests++;
      fails++;
      $display("FAIL wait_idle: busy_o stuck high, got 1 expected 0");
    end
  endtask

  // Issues one op; returns in cycle N+1 with the expected latency.
  task automatic issue(input logic [2:0] f, input logic [W-1:0] a, input logic [W-1:0] b,
                       input bit push, output int lat);
    exp_t e;
    wait_idle();
    @(negedge clk);
    start_i = 1'b1; funct3_i = f; rs1_i = a; rs2_i = b;
    @(posedge clk);
    #1;
    start_i = 1'b0;
    lat = ref_lat(f, a, b);
    if (push) begin
      e.res = ref_fn(f, a, b);
      e.lat = lat;
      e.acc = cyc;
      sb.push_back(e);
      last_res = e.res;
    end
    @(negedge clk);
    check("busy_after_accept", {31'b0, busy_o}, 32'd1);
  endtask

  initial begin
    int lat;
    logic [2:0] f;
    reset = 1'b1; start_i = 1'b1; funct3_i = 3'd0; rs1_i = 32'd5; rs2_i = 32'd6; kill_i = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_busy", {31'b0, busy_o}, '0);
    check("reset_done", {31'b0, done_o}, '0);
    check("reset_res", res_o, '0);
    start_i = 1'b0; reset = 1'b0;
    @(negedge clk);
    check("start_during_reset_ignored", {31'b0, busy_o}, '0);

    issue(3'd0, 32'd7, -32'd3, 1, lat);
    issue(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1, lat);
    issue(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1, lat);
    issue(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1, lat);
    issue(3'd4, -32'd7, 32'd2, 1, lat);
    issue(3'd6, -32'd7, 32'd2, 1, lat);
    issue(3'd5, 32'd100, 32'd0, 1, lat);
    issue(3'd7, 32'd100, 32'd0, 1, lat);
    issue(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 1, lat);
    issue(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 1, lat);
    issue(3'd5, 32'h8000_0000, 32'hFFFF_FFFF, 1, lat);

    // Kill mid-divide, with an ignored start in between.
    wait_idle();
    issue(3'd5, 32'd1000, 32'd7, 0, lat);
    repeat (4) @(negedge clk);
    start_i = 1'b1; funct3_i = 3'd0; rs1_i = 32'd9; rs2_i = 32'd9;
    @(negedge clk);
    start_i = 1'b0;
    repeat (4) @(negedge clk);
    kill_i = 1'b1;
    @(negedge clk);
    kill_i = 1'b0;
    check("kill_busy", {31'b0, busy_o}, '0);
    check("kill_done", {31'b0, done_o}, '0);
    check("kill_res_held", res_o, last_res);
    repeat (40) @(negedge clk);

    // Reset mid-divide.
    issue(3'd4, 32'd1000, 32'd3, 0, lat);
    repeat (19) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("midreset_busy", {31'b0, busy_o}, '0);
    check("midreset_done", {31'b0, done_o}, '0);
    check("midreset_res", res_o, '0);
    issue(3'd0, 32'd3, 32'd4, 1, lat);

    for (int i = 0; i < 40; i++) begin
      f = 3'($urandom_range(0, 7));
      issue(f, pick(), pick(), 1, lat);
      if (lat > 6 && $urandom_range(0, 1) == 1) begin
        repeat (4) @(negedge clk);
        start_i = 1'b1; funct3_i = 3'($urandom_range(0, 7)); rs1_i = $urandom; rs2_i = $urandom;
        @(negedge clk);
        start_i = 1'b0;
      end
    end

    wait_idle();
    for (int i = 0; i < 10 && sb.size() != 0; i++) @(negedge clk);
    check("scoreboard_drained", W'(sb.size()), '0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/muldiv_seq.md
MULDIV_SEQ -- requirements
Module: muldiv_seq

Interface
REQ-001 SHALL have parameter DWIDTH, default 32, operand/result width.
REQ-002 SHALL have parameter ITER, default DWIDTH, iterations per iterative operation.
REQ-003 SHALL have port clk  input  1  rising-edge clock.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port start_i  input  1  request to begin an operation; sampled only in IDLE.
REQ-006 SHALL have port funct3_i  input  3  M-extension op: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
REQ-007 SHALL have ports rs1_i, rs2_i  input  DWIDTH  operands, captured on accept.
REQ-008 SHALL have port kill_i  input  1  pipeline flush; abandons any operation.
REQ-009 SHALL have port busy_o  output  1  high while not IDLE; execute stage stalls on it.
REQ-010 SHALL have port done_o  output  1  one-cycle pulse, result valid.
REQ-011 SHALL have port res_o  output  DWIDTH  result, held from done_o until the next accept.

Function
REQ-012 SHALL implement FSM states IDLE, CALC, DONE.
REQ-013 IDLE -> CALC when start_i=1 and kill_i=0; SHALL latch funct3_i, rs1_i and rs2_i, and load iteration counter with ITER-1.
REQ-014 CALC SHALL perform one shift-add multiply step or one restoring divide step per cycle on operand magnitudes; counter decrements each cycle.
REQ-015 CALC -> DONE when counter = 0; DONE -> IDLE unconditionally after one cycle; done_o=1 only in DONE.
REQ-016 Latency: accept at cycle N -> done_o at cycle N+ITER+1; busy_o high cycles N+1..N+ITER+1.
REQ-017 start_i while busy_o=1 SHALL be ignored; no queueing.
REQ-018 Signed ops SHALL convert operands to magnitude at accept and apply sign correction in DONE; MULHSU treats rs1 signed, rs2 unsigned.
REQ-019 MUL returns product[DWIDTH-1:0]; MULH/MULHSU/MULHU return product[2*DWIDTH-1:DWIDTH].
REQ-020 Divide by zero SHALL skip CALC (IDLE -> DONE): DIV/DIVU give all-ones, REM/REMU give rs1.
REQ-021 DIV with rs1 = most-negative and rs2 = -1 SHALL skip CALC: quotient = rs1, REM = 0.
REQ-022 Remainder sign SHALL follow dividend; quotient truncates toward zero.
REQ-023 kill_i=1 in any state SHALL force IDLE next cycle with no done_o; kill_i wins over simultaneous start_i; res_o unchanged.

Reset
REQ-024 reset SHALL force IDLE, busy_o=0, done_o=0, res_o=0, counter=0 on the next edge, including mid-operation.
REQ-025 start_i during reset SHALL be ignored.

Configuration
REQ-026 With MULDIV_FAST_MUL_EN defined, MUL/MULH/MULHSU/MULHU SHALL use a single-cycle combinational multiplier (IDLE -> DONE, done_o at N+1); divide ops are unchanged.
REQ-027 Without MULDIV_FAST_MUL_EN, all ops SHALL use the iterative path of REQ-014/016.

Structure
REQ-028 Package muldiv_pkg SHALL hold the funct3 op enum, the FSM state enum and the default ITER constant.
REQ-029 Combinational sub-module muldiv_step SHALL compute one multiply or divide iteration (next partial result and next remainder), instantiated once.

Verification
REQ-030 MUL, rs1=7, rs2=-3 -> done_o at N+33, res_o=0xFFFFFFEB; with MULDIV_FAST_MUL_EN, at N+1.
REQ-031 MULHU, 0xFFFFFFFF * 0xFFFFFFFF -> res_o=0xFFFFFFFE; MULH, same operands -> 0x00000000.
REQ-032 DIV -7/2 -> res_o=0xFFFFFFFD; REM -7/2 -> 0xFFFFFFFF; DIVU 100/0 -> 0xFFFFFFFF at N+1.
REQ-033 DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000; REM same operands -> 0, done_o at N+1.
REQ-034 Accept DIVU, assert kill_i at N+10 -> busy_o=0 at N+11, no done_o; start_i at N+5 ignored.
REQ-035 Reset at N+20 mid-DIV -> IDLE, res_o=0, busy_o=0; new MUL 3*4 after reset -> res_o=12.
